// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and default width.
package serial_adder_ctrl_pkg;

  localparam int unsigned WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage : serial_adder_ctrl_pkg

// File: rtl/fa_bit_cell.sv
// One-bit gate-level full adder; the only arithmetic element of the serial adder.
module fa_bit_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  logic half_sum;

  assign half_sum = a ^ b;
  assign sum      = half_sum ^ cin;
  assign carry    = (a & b) | (cin & half_sum);

endmodule : fa_bit_cell

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: LSB-first, one bit per clock through a single full-adder cell,
// with a start/busy/done handshake and a registered carry fed back each cycle.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sa_q, sa_d;
  logic [WIDTH-1:0]   sb_q, sb_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               cell_sum;
  logic               cell_carry;

  fa_bit_cell u_cell (
    .a     (sa_q[0]),
    .b     (sb_q[0]),
    .cin   (carry_q),
    .sum   (cell_sum),
    .carry (cell_carry)
  );

  // Next-state and datapath update; busy/done are derived from the next state
  // so they appear registered in the same cycle as the state they describe.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        sum_d   = (WIDTH'(cell_sum) << (WIDTH - 1)) | (sum_q >> 1);
        carry_d = cell_carry;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          cout_d  = cell_carry;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule : serial_adder_ctrl

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: an 8-bit and a 1-bit instance
// compared against plain integer addition.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst;

  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;

  logic       start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one 8-bit addition and follow it to its done pulse (bounded wait).
  // prev: {cout,sum} right after acceptance; lat: cycles from acceptance to done.
  task automatic do_add8(input logic [7:0] a, input logic [7:0] b, input logic c,
                         output logic [8:0] res, output logic [8:0] prev,
                         output int lat, output bit busy_ok);
    start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
    step();
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    prev = {cout8, sum8};
    lat = 0;
    busy_ok = 1'b1;
    while (!done8 && lat < 40) begin
      if (!busy8) busy_ok = 1'b0;
      step();
      lat++;
    end
    res = {cout8, sum8};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++;
    if ({busy8, done8, cout8, sum8} !== 11'd0) begin
      errors++;
      $display("FAIL reset8: busy=%b done=%b cout=%b sum=%h, required all zero", busy8, done8, cout8, sum8);
    end
    checks++;
    if ({busy1, done1, cout1, sum1} !== 4'd0) begin
      errors++;
      $display("FAIL reset1: busy=%b done=%b cout=%b sum=%h, required all zero", busy1, done1, cout1, sum1);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [8:0] res, prev;
    int lat;
    bit bok;
    do_add8(8'h5A, 8'h3C, 1'b0, res, prev, lat, bok);
    checks++;
    if (res !== 9'h096) begin errors++; $display("FAIL basic_sum: got %h, required 096", res); end
    checks++;
    if (lat !== 8) begin errors++; $display("FAIL basic_latency: got %0d, required 8", lat); end
    checks++;
    if (!bok || busy8 !== 1'b0) begin
      errors++; $display("FAIL basic_busy: busy_run_ok=%b busy_at_done=%b, required 1/0", bok, busy8);
    end
    step();
    checks++;
    if (done8 !== 1'b0 || res !== {cout8, sum8}) begin
      errors++; $display("FAIL basic_pulse_hold: done=%b result=%h, required 0/%h", done8, {cout8, sum8}, res);
    end
  endtask

  task automatic test_carry();
    logic [8:0] res, prev;
    int lat;
    bit bok;
    do_add8(8'hFF, 8'h01, 1'b0, res, prev, lat, bok);
    checks++;
    if (res !== 9'h100) begin errors++; $display("FAIL carry_ff_01: got %h, required 100", res); end
    step();
    do_add8(8'hFF, 8'hFF, 1'b1, res, prev, lat, bok);
    checks++;
    if (prev !== 9'h100) begin errors++; $display("FAIL carry_hold_prev: got %h, required 100", prev); end
    checks++;
    if (res !== 9'h1FF) begin errors++; $display("FAIL carry_ff_ff_1: got %h, required 1ff", res); end
    step();
  endtask

  task automatic test_ignore_start();
    int ndone = 0;
    logic [8:0] res = '0;
    start8 = 1'b1; a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0;
    step();
    start8 = 1'b0;
    step(); step();
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h10;
    step();
    start8 = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (done8) begin ndone++; res = {cout8, sum8}; end
      step();
    end
    checks++;
    if (ndone !== 1) begin errors++; $display("FAIL ignore_done_count: got %0d, required 1", ndone); end
    checks++;
    if (res !== 9'h002) begin errors++; $display("FAIL ignore_sum: got %h, required 002", res); end
  endtask

  task automatic test_reset_mid();
    int ndone = 0;
    logic [8:0] res, prev;
    int lat;
    bit bok;
    start8 = 1'b1; a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b1;
    step();
    start8 = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({busy8, done8, cout8, sum8} !== 11'd0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b cout=%b sum=%h, required all zero", busy8, done8, cout8, sum8);
    end
    for (int i = 0; i < 12; i++) begin
      if (done8) ndone++;
      step();
    end
    checks++;
    if (ndone !== 0) begin errors++; $display("FAIL reset_mid_no_done: got %0d pulses, required 0", ndone); end
    do_add8(8'h0F, 8'h01, 1'b0, res, prev, lat, bok);
    checks++;
    if (res !== 9'h010) begin errors++; $display("FAIL reset_mid_fresh: got %h, required 010", res); end
    step();
  endtask

  task automatic test_width1();
    for (int k = 7; k >= 0; k--) begin
      logic [2:0] v;
      logic [1:0] exp;
      int lat = 0;
      v = 3'(k);
      exp = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
      start1 = 1'b1; a1 = v[2]; b1 = v[1]; cin1 = v[0];
      step();
      start1 = 1'b0;
      while (!done1 && lat < 10) begin step(); lat++; end
      checks++;
      if ({cout1, sum1} !== exp || lat !== 1) begin
        errors++;
        $display("FAIL width1 a=%b b=%b cin=%b: got %b lat %0d, required %b lat 1",
                 v[2], v[1], v[0], {cout1, sum1}, lat, exp);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] res, prev, exp;
    logic [7:0] a, b;
    logic c;
    int lat;
    bit bok;
    for (int i = 0; i < 500; i++) begin
      a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
      exp = 9'(a) + 9'(b) + 9'(c);
      do_add8(a, b, c, res, prev, lat, bok);
      checks++;
      if (res !== exp || lat !== 8 || !bok) begin
        errors++;
        $display("FAIL b2b[%0d] %h+%h+%b: got %h lat %0d busy_ok %b, required %h lat 8 busy_ok 1",
                 i, a, b, c, res, lat, bok, exp);
      end
      step();
    end
  endtask

  initial begin
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_carry();
    test_ignore_start();
    test_reset_mid();
    test_width1();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_serial_adder_ctrl
